// File: rtl/mod3_job_scheduler.sv
// Round-robin front end that time-shares one bit-serial mod-3 engine between
// NREQ word-level requesters and returns each remainder tagged with its requester id.
module mod3_job_scheduler #(
    parameter int W    = 8,
    parameter int NREQ = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              eng_clr,
    output logic              eng_bit,
    input  logic [1:0]        eng_rem,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [1:0]        resp_rem,
    output logic              resp_div3,
    output logic              busy,
    output logic              mism
);
    localparam int CNTW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_RESP} state_t;

    // valid/ready: a transfer happens on any rising edge where both are high;
    // req_valid/req_data and resp_* stay stable until their transfer completes.
    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, id, grant, cand;
    logic [IDW:0]    sum;
    logic            any_valid;
    logic [W-1:0]    shreg, chk_word, chk_mod, word_sel;
    logic [CNTW-1:0] cnt;

    // Scan from highest offset down so the last hit is the first valid at/after rr_ptr.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            cand = sum[IDW-1:0];
            if (req_valid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign word_sel = req_data[int'(grant)*W +: W];
    assign chk_mod  = chk_word % W'(3);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        eng_clr   = 1'b1;
        eng_bit   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (any_valid && rst) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = S_SHIFT;
                end
            end
            S_SHIFT: begin
                eng_clr = 1'b0;
                eng_bit = shreg[W-1];
                if (cnt == '0)
                    state_nxt = S_WAIT;
            end
            S_WAIT: state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            id         <= '0;
            shreg      <= '0;
            chk_word   <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_rem   <= 2'd0;
            resp_div3  <= 1'b0;
            mism       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        shreg    <= word_sel;
                        chk_word <= word_sel;
                        id       <= grant;
                        cnt      <= CNTW'(W - 1);
                    end
                end
                S_SHIFT: begin
                    shreg <= shreg << 1;
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                end
                S_WAIT: begin
                    resp_valid <= 1'b1;
                    resp_rem   <= eng_rem;
                    resp_div3  <= (eng_rem == 2'd0);
                    resp_id    <= id;
                    // Cross-check the engine against a direct modulo of the latched word.
                    if (eng_rem != chk_mod[1:0] || eng_rem == 2'd3)
                        mism <= 1'b1;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod3_job_scheduler.sv
// Directed bench for mod3_job_scheduler with a behavioural serial mod-3 engine
// that can be switched into a faulty (remainder+1) mode.
module tb_mod3_job_scheduler;
    localparam int W    = 8;
    localparam int NREQ = 2;
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              eng_clr, eng_bit;
    logic [1:0]        eng_rem;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [IDW-1:0]    resp_id;
    logic [1:0]        resp_rem;
    logic              resp_div3, busy, mism;

    mod3_job_scheduler #(.W(W), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .eng_clr(eng_clr), .eng_bit(eng_bit), .eng_rem(eng_rem),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_rem(resp_rem), .resp_div3(resp_div3), .busy(busy), .mism(mism)
    );

    always #5 clk = ~clk;

    // Behavioural div_by_3 engine; fault adds 1 to the reported remainder.
    logic [1:0] eng_r = 2'd0;
    logic       fault = 1'b0;
    always @(posedge clk) begin
        if (eng_clr) eng_r <= 2'd0;
        else         eng_r <= 2'(({eng_r, eng_bit}) % 3);
    end
    assign eng_rem = fault ? eng_r + 2'd1 : eng_r;

    int total  = 0;
    int passed = 0;
    logic exp_mism = 1'b0;
    logic [1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // One full job: accept check, bit stream, latency, response, optional stall
    // with another requester pending (pend >= 0), then handshake.
    task automatic run_job(input int rid, input logic [W-1:0] d, input logic [1:0] erem,
                           input int stall, input int pend);
        int lat;
        logic [1:0] e;
        req_valid = '0;
        req_valid[rid] = 1'b1;
        req_data[rid*W +: W] = d;
        #1;
        chk("accept_ready", req_ready, oh(rid));
        exp_q.push_back(erem);
        cyc();
        req_valid = '0;
        lat = 1;
        for (int b = W - 1; b >= 0; b--) begin
            chk("eng_bit", eng_bit, d[b]);
            chk("shift_clr", eng_clr, 1'b0);
            cyc();
            lat++;
        end
        while (!resp_valid && lat < 40) begin
            cyc();
            lat++;
        end
        chk("latency", lat, W + 2);
        e = exp_q.pop_front();
        chk("resp_id", resp_id, rid);
        chk("resp_rem", resp_rem, e);
        chk("resp_div3", resp_div3, e == 2'd0);
        chk("mism", mism, exp_mism);
        if (pend >= 0) begin
            req_valid[pend] = 1'b1;
            req_data[pend*W +: W] = 8'd200;
        end
        for (int s = 0; s < stall; s++) begin
            cyc();
            chk("stall_valid", resp_valid, 1'b1);
            chk("stall_id", resp_id, rid);
            chk("stall_rem", resp_rem, e);
            chk("stall_busy", busy, 1'b1);
            chk("stall_ready", req_ready, '0);
        end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("post_valid", resp_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        if (pend >= 0) chk("resume_ready", req_ready, oh(pend));
    endtask

    typedef struct {
        int         rid;
        logic [W-1:0] data;
        logic [1:0] rem;
    } vec_t;

    vec_t vecs[7];
    int   hits;
    int   waitc;

    initial begin
        vecs[0] = '{0, 8'd9,   2'd0};
        vecs[1] = '{1, 8'd10,  2'd1};
        vecs[2] = '{1, 8'd11,  2'd2};
        vecs[3] = '{1, 8'd255, 2'd0};
        vecs[4] = '{1, 8'd0,   2'd0};
        vecs[5] = '{0, 8'd200, 2'd2};
        vecs[6] = '{1, 8'd3,   2'd0};

        // Reset values, with a request held to show it is not accepted in reset.
        req_valid = 2'b01;
        req_data  = {8'd0, 8'd9};
        cyc();
        cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_clr", eng_clr, 1'b1);
        chk("rst_bit", eng_bit, 1'b0);
        chk("rst_ready", req_ready, '0);
        chk("rst_valid", resp_valid, 1'b0);
        chk("rst_id", resp_id, '0);
        chk("rst_rem", resp_rem, 2'd0);
        chk("rst_div3", resp_div3, 1'b0);
        chk("rst_mism", mism, 1'b0);
        req_valid = '0;
        rst = 1'b1;
        cyc();

        // Single-requester table vectors.
        foreach (vecs[i]) run_job(vecs[i].rid, vecs[i].data, vecs[i].rem, 0, -1);

        // Stall in RESP with requester 1 waiting, then immediate follow-on accept.
        run_job(0, 8'd11, 2'd2, 5, 1);
        run_job(1, 8'd200, 2'd2, 0, -1);

        // Both requesters valid from reset: grants must alternate.
        do_reset();
        req_data   = {8'd10, 8'd9};
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            waitc = 0;
            while (req_ready == '0 && waitc < 30) begin
                cyc();
                waitc++;
            end
            chk("rr_grant", req_ready, oh(k % 2));
            chk("rr_accept_wait", waitc, 0);
            waitc = 0;
            cyc();
            while (!resp_valid && waitc < 30) begin
                cyc();
                waitc++;
            end
            chk("rr_resp_id", resp_id, k % 2);
            chk("rr_resp_rem", resp_rem, (k % 2) ? 2'd1 : 2'd0);
            cyc();
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        cyc();

        // Reset during SHIFT cycle 4 drops the job.
        req_valid = 2'b01;
        req_data[0 +: W] = 8'hAA;
        #1;
        chk("t5_accept", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        repeat (3) cyc();
        chk("t5_in_shift", eng_clr, 1'b0);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_clr", eng_clr, 1'b1);
        chk("t5_valid", resp_valid, 1'b0);
        hits = 0;
        repeat (15) begin
            cyc();
            if (resp_valid) hits++;
        end
        chk("t5_no_resp", hits, 0);
        run_job(0, 8'd7, 2'd1, 0, -1);

        // Faulty engine: mism sets and stays set through good jobs.
        fault    = 1'b1;
        exp_mism = 1'b1;
        run_job(0, 8'd9, 2'd1, 0, -1);
        fault = 1'b0;
        run_job(1, 8'd10, 2'd1, 0, -1);
        run_job(0, 8'd255, 2'd0, 0, -1);
        do_reset();
        exp_mism = 1'b0;
        chk("mism_cleared", mism, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
